// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: opcodes, NOP encoding and fetch bundle layout.
// The bundle packer lives here so producers and consumers agree on field placement.
package riscv_pkg;

    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    localparam int FETCH_W    = 128;
    localparam int PC1_LSB    = 0;
    localparam int INSTR1_LSB = 32;
    localparam int PC2_LSB    = 64;
    localparam int INSTR2_LSB = 96;

    typedef logic [FETCH_W-1:0] fetch_bundle_t;

    // rdata[31:0] is the word at pc, rdata[63:32] the word at pc+4.
    function automatic fetch_bundle_t pack_bundle(input logic [31:0] pc,
                                                  input logic [63:0] rdata);
        fetch_bundle_t b;
        b                      = '0;
        b[PC1_LSB    +: 32]    = pc;
        b[INSTR1_LSB +: 32]    = rdata[31:0];
        b[PC2_LSB    +: 32]    = pc + 32'd4;
        b[INSTR2_LSB +: 32]    = rdata[63:32];
        return b;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO for fetch bundles: an output register backed by one skid entry.
// Flush drops both entries; incoming data in a flush cycle is also dropped.
module fetch_skid_buf
    import riscv_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    input  fetch_bundle_t in_data,
    input  logic          out_ready,
    output logic          out_valid,
    output fetch_bundle_t out_data,
    output logic          skid_valid
);

    fetch_bundle_t out_data_q, out_data_d;
    fetch_bundle_t skid_data_q, skid_data_d;
    logic          out_valid_q, out_valid_d;
    logic          skid_valid_q, skid_valid_d;
    logic          consume;

    assign consume = out_valid_q & out_ready;

    always_comb begin
        out_data_d   = out_data_q;
        skid_data_d  = skid_data_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (consume) begin
            out_valid_d = skid_valid_q;
            if (skid_valid_q) begin
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end
        end
        // Bypass into the output register only when nothing older is waiting.
        if (in_valid) begin
            if (!out_valid_q || (consume && !skid_valid_q)) begin
                out_data_d  = in_data;
                out_valid_d = 1'b1;
            end else begin
                skid_data_d  = in_data;
                skid_valid_d = 1'b1;
            end
        end
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q   <= '0;
            skid_data_q  <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_data_q   <= out_data_d;
            skid_data_q  <= skid_data_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst || flush)
        !(in_valid && out_valid_q && skid_valid_q && !consume));

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign skid_valid = skid_valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Dual-issue fetch stage: owns the PC, issues 64-bit reads, packs responses into bundles
// and applies scheduler/execute redirects. Requests are throttled so a response always fits.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [31:0]         imem_addr,
    input  logic [63:0]         imem_rdata,
    output logic [FETCH_W-1:0]  fetch_data,
    output logic                fetch_valid,
    input  logic                fetch_ready,
    input  logic                jal,
    input  logic [31:0]         jal_addr,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_addr
);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic          inflight_valid_q, inflight_valid_d;
    logic          redirect_now;
    logic          issue;
    logic          skid_valid;
    logic [31:0]   target;
    fetch_bundle_t rsp_bundle;

    always_comb begin
        redirect_now = redirect_valid | (jal & fetch_valid & fetch_ready);
        target       = redirect_valid ? redirect_addr : jal_addr;
        target[1:0]  = 2'b00;
        // Stall while a response is due and only the skid slot would be left for the next one.
        issue        = ~rst & ~redirect_now & ~skid_valid
                     & ~(fetch_valid & ~fetch_ready & inflight_valid_q);

        pc_d             = pc_q;
        inflight_pc_d    = inflight_pc_q;
        inflight_valid_d = issue;
        if (redirect_now) begin
            pc_d = target;
        end else if (issue) begin
            pc_d          = pc_q + 32'd8;
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q             <= RESET_PC;
            inflight_pc_q    <= '0;
            inflight_valid_q <= 1'b0;
        end else begin
            pc_q             <= pc_d;
            inflight_pc_q    <= inflight_pc_d;
            inflight_valid_q <= inflight_valid_d;
        end
    end

    assign rsp_bundle = pack_bundle(inflight_pc_q, imem_rdata);
    assign imem_req   = issue;
    assign imem_addr  = pc_q;

    fetch_skid_buf u_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_now),
        .in_valid   (inflight_valid_q & ~redirect_now),
        .in_data    (rsp_bundle),
        .out_ready  (fetch_ready),
        .out_valid  (fetch_valid),
        .out_data   (fetch_data),
        .skid_valid (skid_valid)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed cycle table for fetch_unit plus a ready-toggling scoreboard phase.
module tb_fetch_unit;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic [63:0]  imem_rdata = '0;
    logic [127:0] fetch_data;
    logic         fetch_valid;
    logic         fetch_ready = 1'b1;
    logic         jal = 1'b0;
    logic [31:0]  jal_addr = '0;
    logic         redirect_valid = 1'b0;
    logic [31:0]  redirect_addr = '0;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_unit #(.RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .fetch_data     (fetch_data),
        .fetch_valid    (fetch_valid),
        .fetch_ready    (fetch_ready),
        .jal            (jal),
        .jal_addr       (jal_addr),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr)
    );

    always #5 clk = ~clk;

    // Memory: word at byte address a is 0x100 + a/4.
    function automatic logic [31:0] w(input logic [31:0] a);
        return 32'h100 + (a >> 2);
    endfunction

    function automatic logic [127:0] bnd(input logic [31:0] p);
        logic [31:0] p2;
        p2 = p + 32'd4;
        return {w(p2), p2, w(p), p};
    endfunction

    always @(posedge clk)
        if (imem_req) imem_rdata <= {w(imem_addr + 32'd4), w(imem_addr)};

    typedef struct {
        logic         rst, rdy, jal;
        logic [31:0]  jaddr;
        logic         rv;
        logic [31:0]  raddr;
        logic         req;
        logic [31:0]  addr;
        logic         vld;
        logic         chk_d;
        logic [127:0] data;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic rdy, input logic j,
                                input logic [31:0] ja, input logic rv, input logic [31:0] ra,
                                input logic req, input logic [31:0] addr, input logic vld,
                                input logic cd, input logic [127:0] d);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.jal = j; v.jaddr = ja; v.rv = rv; v.raddr = ra;
        v.req = req; v.addr = addr; v.vld = vld; v.chk_d = cd; v.data = d;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    int          acc;
    logic [31:0] exp_pc;

    initial begin
        //          rst rdy jal jaddr         rv raddr          req addr          vld chk data
        tbl.push_back(mk(1, 1, 0, 0,          0, 0,            0, 32'h0,         0, 1, '0));        // reset
        tbl.push_back(mk(0, 1, 0, 0,          0, 0,            1, 32'h0,         0, 0, '0));        // c0
        tbl.push_back(mk(0, 1, 0, 0,          0, 0,            1, 32'h8,         0, 0, '0));
        tbl.push_back(mk(0, 1, 0, 0,          0, 0,            1, 32'h10,        1, 1, bnd(32'h0)));
        tbl.push_back(mk(0, 1, 0, 0,          0, 0,            1, 32'h18,        1, 1, bnd(32'h8)));
        for (int k = 0; k < 4; k++)                                                                 // c4-c7 stall
            tbl.push_back(mk(0, 0, 0, 0,      0, 0,            0, 32'h20,        1, 1, bnd(32'h10)));
        tbl.push_back(mk(0, 1, 0, 0,          0, 0,            0, 32'h20,        1, 1, bnd(32'h10))); // c8
        tbl.push_back(mk(0, 1, 0, 0,          0, 0,            1, 32'h20,        1, 1, bnd(32'h18)));
        tbl.push_back(mk(0, 1, 0, 0,          0, 0,            1, 32'h28,        0, 0, '0));
        tbl.push_back(mk(0, 1, 1, 32'h204,    0, 0,            0, 32'h30,        1, 1, bnd(32'h20))); // c11 jal
        tbl.push_back(mk(0, 1, 0, 0,          0, 0,            1, 32'h204,       0, 0, '0));
        tbl.push_back(mk(0, 1, 0, 0,          0, 0,            1, 32'h20C,       0, 0, '0));
        tbl.push_back(mk(0, 1, 0, 0,          0, 0,            1, 32'h214,       1, 1, bnd(32'h204)));
        tbl.push_back(mk(0, 0, 0, 0,          0, 0,            0, 32'h21C,       1, 1, bnd(32'h20C))); // c15 fill skid
        tbl.push_back(mk(0, 0, 1, 32'h300,    1, 32'h402,      0, 32'h21C,       1, 1, bnd(32'h20C))); // c16 flush
        tbl.push_back(mk(0, 1, 0, 0,          0, 0,            1, 32'h400,       0, 0, '0));
        tbl.push_back(mk(0, 1, 0, 0,          0, 0,            1, 32'h408,       0, 0, '0));
        tbl.push_back(mk(0, 1, 0, 0,          0, 0,            1, 32'h410,       1, 1, bnd(32'h400)));
        tbl.push_back(mk(0, 1, 0, 0,          1, 32'hFFFF_FFFA, 0, 32'h418,      1, 1, bnd(32'h408))); // c20
        tbl.push_back(mk(0, 1, 0, 0,          0, 0,            1, 32'hFFFF_FFF8, 0, 0, '0));
        tbl.push_back(mk(0, 1, 0, 0,          0, 0,            1, 32'h0,         0, 0, '0));        // wrap
        tbl.push_back(mk(0, 1, 0, 0,          0, 0,            1, 32'h8,         1, 1, bnd(32'hFFFF_FFF8)));
        tbl.push_back(mk(0, 1, 0, 0,          0, 0,            1, 32'h10,        1, 1, bnd(32'h0)));
        tbl.push_back(mk(0, 0, 0, 0,          0, 0,            0, 32'h18,        1, 1, bnd(32'h8)));  // c25
        tbl.push_back(mk(1, 0, 0, 0,          0, 0,            0, 32'h18,        1, 1, bnd(32'h8)));  // c26 rst
        tbl.push_back(mk(1, 1, 0, 0,          1, 32'h500,      0, 32'h0,         0, 1, '0));
        tbl.push_back(mk(0, 1, 1, 32'h300,    0, 0,            1, 32'h0,         0, 0, '0));        // jal ignored
        tbl.push_back(mk(0, 1, 1, 32'h300,    0, 0,            1, 32'h8,         0, 0, '0));
        tbl.push_back(mk(0, 1, 0, 0,          0, 0,            1, 32'h10,        1, 1, bnd(32'h0)));  // c30

        foreach (tbl[i]) begin
            @(negedge clk);
            rst            = tbl[i].rst;
            fetch_ready    = tbl[i].rdy;
            jal            = tbl[i].jal;
            jal_addr       = tbl[i].jaddr;
            redirect_valid = tbl[i].rv;
            redirect_addr  = tbl[i].raddr;
            #1;
            check($sformatf("row%0d imem_req", i), {127'b0, imem_req}, {127'b0, tbl[i].req});
            check($sformatf("row%0d imem_addr", i), {96'b0, imem_addr}, {96'b0, tbl[i].addr});
            check($sformatf("row%0d fetch_valid", i), {127'b0, fetch_valid}, {127'b0, tbl[i].vld});
            if (tbl[i].chk_d)
                check($sformatf("row%0d fetch_data", i), fetch_data, tbl[i].data);
        end

        // Random back-pressure: every accepted bundle must be the next sequential one.
        acc    = 0;
        exp_pc = 32'h8;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            rst            = 1'b0;
            jal            = 1'b0;
            redirect_valid = 1'b0;
            fetch_ready    = ($urandom_range(0, 3) != 0);
            #1;
            if (fetch_valid && fetch_ready) begin
                check($sformatf("sb%0d bundle", acc), fetch_data, bnd(exp_pc));
                exp_pc = exp_pc + 32'd8;
                acc++;
            end
        end
        check("sb accepted>=20", {127'b0, acc >= 20}, {127'b0, 1'b1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Dual-issue instruction fetch stage that sits directly upstream of the scheduler. It owns the PC and issues one 64-bit read of two consecutive words per request to a synchronous instruction memory. It packs each response into the 128-bit fetch bundle the scheduler consumes, and applies redirects from the scheduler's jal output or from execute. A two-entry output buffer (output register plus skid) absorbs downstream back-pressure without losing a memory response.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, fixed value for unused slots (addi x0,x0,0)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  read request this cycle
imem_addr  out  32  word-aligned read address; memory returns {mem[addr+4], mem[addr]}
imem_rdata  in  64  read data, valid exactly one cycle after imem_req; [31:0] = word at addr
fetch_data  out  128  bundle: [31:0] pc1, [63:32] instr1, [95:64] pc1+4, [127:96] instr2
fetch_valid  out  1  fetch_data holds a live bundle
fetch_ready  in  1  downstream accepts the bundle this cycle
jal  in  1  scheduler redirect request; used only when fetch_valid & fetch_ready
jal_addr  in  32  scheduler redirect target
redirect_valid  in  1  execute-stage redirect (branch/jalr)
redirect_addr  in  32  execute-stage redirect target

Behaviour:
- Reset: pc_q=RESET_PC; inflight_valid, out_valid, skid_valid all 0; fetch_data=0; imem_req=0. The first request issues in the first cycle with rst low.
- Transfer: a bundle is consumed when fetch_valid & fetch_ready. fetch_valid = out_valid. fetch_data is always the output register, never combinational from imem_rdata.
- Issue rule: imem_req = ~rst & ~redirect_now & ~skid_valid & ~(out_valid & ~fetch_ready & inflight_valid). imem_addr=pc_q. On issue: inflight_pc<=pc_q, pc_q<=pc_q+8 (wraps mod 2^32), inflight_valid<=1. Otherwise inflight_valid<=0.
- Response capture, one cycle after issue, with bundle {imem_rdata[63:32], inflight_pc+4, imem_rdata[31:0], inflight_pc}:
  - Output register empty, or being consumed this cycle with skid empty: goes to output register.
  - Otherwise: goes to skid.
  - Skid drains into the output register when the output register is consumed. Ordering stays strictly FIFO.
- The issue rule guarantees a captured response always has a free slot. Overflow is impossible and must be asserted against in simulation.
- Latency: request at cycle t, fetch_valid at t+2. Steady-state throughput is one bundle per cycle while fetch_ready=1.
- Redirect:
  - redirect_now = redirect_valid | (jal & fetch_valid & fetch_ready).
  - Target priority: redirect_addr when redirect_valid; otherwise jal_addr.
  - Target is forced word-aligned: target[1:0] is dropped to 2'b00.
  - In the redirect cycle: pc_q<=target; out_valid, skid_valid and inflight_valid cleared. The in-flight response is discarded. No request issues.
  - The first request to the target issues the next cycle; its bundle is valid 3 cycles after the redirect cycle.
- Simultaneous events:
  - redirect_valid and jal together: redirect_valid wins.
  - A redirect during a stall flushes all buffered bundles.
  - jal without fetch_valid & fetch_ready is ignored.
  - rst overrides everything, including redirects.
- Alignment: non-8-byte-aligned PCs are legal; memory dual-read handles pc_q[2]=1.
- A state FSM is not used; control is the three valid bits plus pc_q.

Decomposition:
- Shared package riscv_pkg:
  - OPC_JAL 7'b1101111, OPC_LOAD, OPC_STORE
  - NOP_INSTR
  - FETCH_W=128
  - Bundle field offsets (PC1_LSB=0, INSTR1_LSB=32, PC2_LSB=64, INSTR2_LSB=96)
- One sub-module, fetch_skid_buf: 128-bit, 2-entry output register plus skid, with valid/ready and a flush input. PC and issue logic stay in fetch_unit.

Test Plan:
- Reset with RESET_PC=0, fetch_ready=1, memory word i = 0x100+i -> imem_addr 0,8,16 on consecutive cycles.
  - First bundle at cycle 2: {0x101, 0x4, 0x100, 0x0}.
  - Then one bundle per cycle.
- Hold fetch_ready=0 for 4 cycles mid-stream -> imem_req drops after at most one extra request.
  - Bundles at pc 0x10 and 0x18 are retained (output + skid).
  - On release, delivery in order with no loss or duplication.
- jal=1, jal_addr=0x204 while bundle pc1=0x20 is accepted -> in-flight bundle (0x28) dropped; next imem_addr=0x204.
  - Next valid bundle pc1=0x204, pc2=0x208, three cycles later.
- redirect_valid=1 with addr 0x400 together with jal to 0x300, fetch_ready=0 -> all buffers flushed; next fetch at 0x400.
- pc_q=0xFFFF_FFF8 -> following imem_addr=0x0000_0000 (wrap).
- rst asserted mid-stall with skid full -> next cycle fetch_valid=0 and imem_req=0; first request after release goes to RESET_PC.
